// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-path definitions: state encoding, instruction width and the bubble word.
package instruction_fetch_unit_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Program counter owner and IF/ID output register; fetches word-indexed instructions
// from a combinational instruction memory with stall, redirect and end-of-image halt.
//
// state | meaning
// IDLE  | one-cycle settle after reset, nothing captured
// FETCH | capture imem word each unstalled cycle, advance pc
// HALT  | fetch stopped at end of image or out-of-range redirect
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                 MEM_DEPTH = 32,
   parameter logic [31:0]        RESET_PC  = 32'd0,
   parameter logic [INSTR_W-1:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [31:0]        redirect_pc_i,
   output logic [31:0]        imem_addr_o,
   input  logic [INSTR_W-1:0] imem_instr_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [31:0]        pc_o,
   output logic               valid_o,
   output logic               halted_o
);

   localparam logic [31:0] DEPTH   = 32'(MEM_DEPTH);
   localparam logic [31:0] LAST_PC = 32'(MEM_DEPTH - 1);

   fetch_state_t state;
   logic [31:0]  pc;
   logic         target_ok;

   assign imem_addr_o = pc;
   assign target_ok   = (redirect_pc_i < DEPTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         state    <= IDLE;
         instr_o  <= NOP_WORD;
         pc_o     <= 32'd0;
         valid_o  <= 1'b0;
         halted_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= FETCH;
            end
            FETCH: begin
               if (redirect_i) begin
                  valid_o <= 1'b0;
                  instr_o <= NOP_WORD;
                  if (target_ok) begin
                     pc <= redirect_pc_i;
                  end else begin
                     state    <= HALT;
                     halted_o <= 1'b1;
                  end
               end else if (!stall_i) begin
                  instr_o <= imem_instr_i;
                  pc_o    <= pc;
                  valid_o <= 1'b1;
                  // last word: present it but keep pc on it so pc+1 never leaves the image
                  if (pc == LAST_PC) begin
                     state    <= HALT;
                     halted_o <= 1'b1;
                  end else begin
                     pc <= pc + 32'd1;
                  end
               end
            end
            HALT: begin
               if (redirect_i && target_ok) begin
                  pc       <= redirect_pc_i;
                  halted_o <= 1'b0;
                  state    <= FETCH;
                  valid_o  <= 1'b0;
                  instr_o  <= NOP_WORD;
               end else if (!stall_i) begin
                  valid_o <= 1'b0;
                  instr_o <= NOP_WORD;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: driver pushes hand-computed post-edge expectations, monitor pops and compares.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        valid_o;
   logic        halted_o;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        halted;
      int          step;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem [32];
   int          tests_run = 0;
   int          tests_failed = 0;
   int          step_no = 0;

   instruction_fetch_unit #(.MEM_DEPTH(32), .RESET_PC(32'd0), .NOP_WORD(32'h0)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_addr_o   (imem_addr_o),
      .imem_instr_i  (imem_instr_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .valid_o       (valid_o),
      .halted_o      (halted_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      imem_instr_i = 32'hDEAD_BEEF;
      if (imem_addr_o < 32'd32) imem_instr_i = mem[imem_addr_o[4:0]];
   end

   task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, step, act, exp);
      end
   endtask

   // monitor: compares the DUT outputs after every edge for which an expectation exists
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_addr", e.step, imem_addr_o, e.addr);
            chk("instr", e.step, instr_o, e.instr);
            chk("pc_o", e.step, pc_o, e.pc);
            chk("valid", e.step, {31'd0, valid_o}, {31'd0, e.valid});
            chk("halted", e.step, {31'd0, halted_o}, {31'd0, e.halted});
         end
      end
   end

   task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input logic [31:0] e_addr, input logic [31:0] e_instr, input logic [31:0] e_pc,
                       input logic e_valid, input logic e_halt);
      exp_t e;
      @(negedge clk);
      rst           = r;
      stall_i       = s;
      redirect_i    = rd;
      redirect_pc_i = rpc;
      step_no++;
      e.addr   = e_addr;
      e.instr  = e_instr;
      e.pc     = e_pc;
      e.valid  = e_valid;
      e.halted = e_halt;
      e.step   = step_no;
      exp_q.push_back(e);
   endtask

   initial begin
      mem[0] = 32'h2001_0003;
      mem[1] = 32'h2002_0003;
      mem[2] = 32'h0022_1818;
      mem[3] = 32'h8C41_000A;
      mem[4] = 32'h1022_0014;
      for (int i = 5; i < 32; i++) mem[i] = 32'hC000_0000 + 32'(i);

      rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;

      // reset and first fetches
      step(1, 0, 0, 0,  0, 0,          0, 0, 0);
      step(1, 0, 0, 0,  0, 0,          0, 0, 0);
      step(0, 0, 0, 0,  0, 0,          0, 0, 0);
      step(0, 0, 0, 0,  1, mem[0],     0, 1, 0);
      step(0, 0, 0, 0,  2, mem[1],     1, 1, 0);
      step(0, 0, 0, 0,  3, mem[2],     2, 1, 0);
      // three stalled cycles
      step(0, 1, 0, 0,  3, mem[2],     2, 1, 0);
      step(0, 1, 0, 0,  3, mem[2],     2, 1, 0);
      step(0, 1, 0, 0,  3, mem[2],     2, 1, 0);
      step(0, 0, 0, 0,  4, mem[3],     3, 1, 0);
      // redirect beats stall
      step(0, 1, 1, 1,  1, 0,          3, 0, 0);
      step(0, 0, 0, 0,  2, mem[1],     1, 1, 0);
      // run to the end of the image
      for (int k = 2; k <= 30; k++)
         step(0, 0, 0, 0, 32'(k + 1), mem[k], 32'(k), 1, 0);
      step(0, 0, 0, 0, 31, mem[31],    31, 1, 1);
      step(0, 1, 0, 0, 31, mem[31],    31, 1, 1);
      step(0, 0, 0, 0, 31, 0,          31, 0, 1);
      // out-of-range redirect in HALT ignored, in-range restarts
      step(0, 0, 1, 40, 31, 0,         31, 0, 1);
      step(0, 0, 1, 0,  0, 0,          31, 0, 0);
      step(0, 0, 0, 0,  1, mem[0],     0, 1, 0);
      step(0, 0, 0, 0,  2, mem[1],     1, 1, 0);
      step(0, 0, 0, 0,  3, mem[2],     2, 1, 0);
      // reset overrides stall and redirect mid-stream
      step(1, 1, 1, 5,  0, 0,          0, 0, 0);
      step(0, 0, 0, 0,  0, 0,          0, 0, 0);
      step(0, 0, 0, 0,  1, mem[0],     0, 1, 0);
      // out-of-range redirect (== depth) from FETCH halts
      step(0, 0, 1, 32, 1, 0,          0, 0, 1);
      step(0, 0, 0, 0,  1, 0,          0, 0, 1);
      // boundary in-range redirect to the last word
      step(0, 0, 1, 31, 31, 0,         0, 0, 0);
      step(0, 0, 0, 0,  31, mem[31],   31, 1, 1);
      step(0, 0, 0, 0,  31, 0,         31, 0, 1);

      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", step_no, 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
